// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - sequences C = A x B over single-port A/B read and C write memories
module matmul_sequencer #(
    parameter int ROW   = 2,
    parameter int INNER = 2,
    parameter int COL   = 2,
    parameter int AW    = 4,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             read_A,
    output logic [AW-1:0]    read_address_A,
    input  logic [7:0]       data_A,
    output logic             read_B,
    output logic [AW-1:0]    read_address_B,
    input  logic [7:0]       data_B,
    output logic             write_C,
    output logic [AW-1:0]    write_address_C,
    output logic [ACC_W-1:0] write_value_C,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LP_INNER = AW'(INNER);
    localparam logic [AW-1:0] LP_COL   = AW'(COL);

    state_t             r_state;
    state_t             w_next;
    logic [AW-1:0]      r_i;
    logic [AW-1:0]      r_j;
    logic [AW-1:0]      r_k;
    logic [ACC_W-1:0]   r_acc;
    logic [AW-1:0]      r_addr_a;
    logic [AW-1:0]      r_addr_b;
    logic [AW-1:0]      r_addr_c;
    logic [ACC_W-1:0]   r_val_c;

    logic [AW-1:0]      w_addr_a;
    logic [AW-1:0]      w_addr_b;
    logic [AW-1:0]      w_addr_c;
    logic [15:0]        w_prod;
    logic               w_last_k;
    logic               w_last_j;
    logic               w_last_i;

    assign w_addr_a = r_i * LP_INNER + r_k;
    assign w_addr_b = r_k * LP_COL + r_j;
    assign w_addr_c = r_i * LP_COL + r_j;
    assign w_prod   = data_A * data_B;
    assign w_last_k = (r_k == AW'(INNER - 1));
    assign w_last_j = (r_j == AW'(COL - 1));
    assign w_last_i = (r_i == AW'(ROW - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and strobes; addresses/data show live values only while strobed
    always_comb begin
        w_next          = r_state;
        read_A          = 1'b0;
        read_B          = 1'b0;
        write_C         = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        read_address_A  = r_addr_a;
        read_address_B  = r_addr_b;
        write_address_C = r_addr_c;
        write_value_C   = r_val_c;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                read_A         = 1'b1;
                read_B         = 1'b1;
                busy           = 1'b1;
                read_address_A = w_addr_a;
                read_address_B = w_addr_b;
                w_next         = S_MAC;
            end
            S_MAC: begin
                busy   = 1'b1;
                w_next = w_last_k ? S_WRITE : S_FETCH;
            end
            S_WRITE: begin
                write_C         = 1'b1;
                busy            = 1'b1;
                write_address_C = w_addr_c;
                write_value_C   = r_acc;
                w_next          = (w_last_i && w_last_j) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Loop indices, accumulator and held copies of the last driven address/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_addr_c <= '0;
            r_val_c  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i   <= '0;
                        r_j   <= '0;
                        r_k   <= '0;
                        r_acc <= '0;
                    end
                end
                S_FETCH: begin
                    r_addr_a <= w_addr_a;
                    r_addr_b <= w_addr_b;
                end
                S_MAC: begin
                    r_acc <= r_acc + {{(ACC_W - 16){1'b0}}, w_prod};
                    if (!w_last_k) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_addr_c <= w_addr_c;
                    r_val_c  <= r_acc;
                    r_k      <= '0;
                    r_acc    <= '0;
                    if (w_last_j) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - randomized self-checking bench for matmul_sequencer
module tb_matmul_sequencer;

    localparam int ROW   = 2;
    localparam int INNER = 2;
    localparam int COL   = 2;
    localparam int AW    = 4;
    localparam int ACC_W = 18;
    localparam int P     = 2 * INNER + 1;
    localparam int NTOT  = ROW * COL * P;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             read_A, read_B, write_C, busy, done;
    logic [AW-1:0]    read_address_A, read_address_B, write_address_C;
    logic [7:0]       data_A = 8'd0;
    logic [7:0]       data_B = 8'd0;
    logic [ACC_W-1:0] write_value_C;

    logic             start3 = 1'b0;
    logic             read_A3, read_B3, write_C3, busy3, done3;
    logic [AW-1:0]    read_address_A3, read_address_B3, write_address_C3;
    logic [7:0]       data_A3 = 8'd0;
    logic [7:0]       data_B3 = 8'd0;
    logic [ACC_W-1:0] write_value_C3;

    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] mem_a3 [16];
    logic [7:0] mem_b3 [16];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mt = 0;

    int wq_a[$];
    int wq_v[$];
    int dq[$];
    int wq3_a[$];
    int wq3_v[$];
    int bq3[$];

    logic [AW-1:0]    e_la = '0, e_lb = '0, e_lc = '0;
    logic [ACC_W-1:0] e_lv = '0;
    logic             e_rd, e_wr, e_busy, e_done;
    int               p, e, ei, ej, ek;

    matmul_sequencer #(.ROW(ROW), .INNER(INNER), .COL(COL), .AW(AW), .ACC_W(ACC_W)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .read_A(read_A), .read_address_A(read_address_A), .data_A(data_A),
        .read_B(read_B), .read_address_B(read_address_B), .data_B(data_B),
        .write_C(write_C), .write_address_C(write_address_C), .write_value_C(write_value_C),
        .busy(busy), .done(done)
    );

    matmul_sequencer #(.ROW(2), .INNER(3), .COL(1), .AW(AW), .ACC_W(ACC_W)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .read_A(read_A3), .read_address_A(read_address_A3), .data_A(data_A3),
        .read_B(read_B3), .read_address_B(read_address_B3), .data_B(data_B3),
        .write_C(write_C3), .write_address_C(write_address_C3), .write_value_C(write_value_C3),
        .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories answering the strobes one cycle later
    always @(posedge clk) begin
        if (read_A)  data_A  <= mem_a[read_address_A];
        if (read_B)  data_B  <= mem_b[read_address_B];
        if (read_A3) data_A3 <= mem_a3[read_address_A3];
        if (read_B3) data_B3 <= mem_b3[read_address_B3];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dot(input int i, input int j);
        int s = 0;
        for (int k = 0; k < INNER; k++)
            s += int'(mem_a[i * INNER + k]) * int'(mem_b[k * COL + j]);
        return s;
    endfunction

    // Reference: cycle position within a run (0 = idle, 1..NTOT busy, NTOT+1 = done cycle)
    always @(posedge clk or posedge rst) begin
        if (rst) mt <= 0;
        else if (mt == 0) mt <= start ? 1 : 0;
        else if (mt == NTOT + 1) mt <= 0;
        else mt <= mt + 1;
    end

    // Per-cycle comparison of every DUT output against the reference schedule
    always @(negedge clk) begin
        if (rst) begin
            e_la = '0; e_lb = '0; e_lc = '0; e_lv = '0;
            chk("rst_read_A", read_A, 0);
            chk("rst_write_C", write_C, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_addr_A", read_address_A, 0);
            chk("rst_value_C", write_value_C, 0);
        end else begin
            e_rd = 1'b0;
            e_wr = 1'b0;
            e_busy = (mt >= 1 && mt <= NTOT);
            e_done = (mt == NTOT + 1);
            if (e_busy) begin
                p = (mt - 1) % P;
                e = (mt - 1) / P;
                ei = e / COL;
                ej = e % COL;
                if (p < 2 * INNER && p % 2 == 0) begin
                    e_rd = 1'b1;
                    ek = p / 2;
                    e_la = AW'(ei * INNER + ek);
                    e_lb = AW'(ek * COL + ej);
                end
                if (p == 2 * INNER) begin
                    e_wr = 1'b1;
                    e_lc = AW'(e);
                    e_lv = ACC_W'(dot(ei, ej));
                end
            end
            chk("read_A", read_A, e_rd);
            chk("read_B", read_B, e_rd);
            chk("write_C", write_C, e_wr);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("read_address_A", read_address_A, e_la);
            chk("read_address_B", read_address_B, e_lb);
            chk("write_address_C", write_address_C, e_lc);
            chk("write_value_C", write_value_C, e_lv);
        end
        if (write_C) begin
            wq_a.push_back(int'(write_address_C));
            wq_v.push_back(int'(write_value_C));
        end
        if (done) dq.push_back(cyc);
    end

    // Log of the 2x3x1 instance
    always @(negedge clk) begin
        if (write_C3) begin
            wq3_a.push_back(int'(write_address_C3));
            wq3_v.push_back(int'(write_value_C3));
        end
        if (read_B3) bq3.push_back(int'(read_address_B3));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, input string nm, output int dcyc);
        dcyc = -1;
        for (int b = 0; b < budget; b++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) chk({nm, "_timeout"}, 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wq_a.delete(); wq_v.delete(); dq.delete();
    endtask

    int scyc, d1, d2, nw;

    initial begin
        for (int a = 0; a < 16; a++) begin
            mem_a[a] = 8'd0; mem_b[a] = 8'd0; mem_a3[a] = 8'd0; mem_b3[a] = 8'd0;
        end
        tick(2);
        chk("reset_busy_lit", busy, 0);
        chk("reset_addr_C_lit", write_address_C, 0);
        rst = 1'b0;
        tick(2);

        // Worked example plus the 2x3x1 instance in parallel
        mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
        mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
        for (int a = 0; a < 6; a++) mem_a3[a] = 8'(a + 1);
        for (int a = 0; a < 3; a++) mem_b3[a] = 8'd1;
        clear_logs();
        start = 1'b1; start3 = 1'b1; scyc = cyc;
        tick(1);
        start = 1'b0; start3 = 1'b0;
        wait_done(60, "ex1", d1);
        chk("ex1_done_latency", d1 - scyc, 21);
        chk("ex1_nwrites", wq_a.size(), 4);
        if (wq_a.size() == 4) begin
            chk("ex1_c0", wq_v[0], 19); chk("ex1_a0", wq_a[0], 0);
            chk("ex1_c1", wq_v[1], 22); chk("ex1_a1", wq_a[1], 1);
            chk("ex1_c2", wq_v[2], 43); chk("ex1_a2", wq_a[2], 2);
            chk("ex1_c3", wq_v[3], 50); chk("ex1_a3", wq_a[3], 3);
        end
        chk("ex1_ndone", dq.size(), 1);
        chk("k3_nwrites", wq3_a.size(), 2);
        if (wq3_a.size() == 2) begin
            chk("k3_c0", wq3_v[0], 6);  chk("k3_a0", wq3_a[0], 0);
            chk("k3_c1", wq3_v[1], 15); chk("k3_a1", wq3_a[1], 1);
        end
        chk("k3_nbreads", bq3.size(), 6);
        if (bq3.size() == 6)
            for (int r = 0; r < 6; r++) chk("k3_b_addr", bq3[r], r % 3);

        // Saturated operands
        for (int a = 0; a < 4; a++) begin mem_a[a] = 8'd255; mem_b[a] = 8'd255; end
        clear_logs();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(60, "max", d1);
        chk("max_nwrites", wq_v.size(), 4);
        foreach (wq_v[r]) chk("max_value", wq_v[r], 130050);

        // Start pulsed repeatedly while busy
        for (int a = 0; a < 4; a++) begin mem_a[a] = 8'($urandom); mem_b[a] = 8'($urandom); end
        clear_logs();
        start = 1'b1;
        for (int n = 0; n < 19; n++) begin
            tick(1);
            start = 1'($urandom_range(0, 1));
        end
        tick(1);
        start = 1'b0;
        wait_done(60, "pulsed", d1);
        tick(3);
        chk("pulsed_nwrites", wq_a.size(), 4);
        chk("pulsed_ndone", dq.size(), 1);

        // Reset right after the second C write
        clear_logs();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        nw = 0;
        for (int b = 0; b < 60 && nw < 2; b++) begin
            @(negedge clk);
            if (write_C) nw++;
        end
        chk("mid_two_writes_seen", nw, 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_read_A", read_A, 0);
        chk("mid_rst_write_C", write_C, 0);
        chk("mid_rst_addr_C", write_address_C, 0);
        chk("mid_rst_value_C", write_value_C, 0);
        tick(2);
        rst = 1'b0;
        tick(12);
        chk("mid_no_more_writes", wq_a.size(), 2);
        chk("mid_no_done", dq.size(), 0);
        clear_logs();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(60, "rerun", d1);
        chk("rerun_nwrites", wq_a.size(), 4);
        if (wq_a.size() > 0) chk("rerun_first_addr", wq_a[0], 0);

        // Start held high: back-to-back runs
        clear_logs();
        start = 1'b1; scyc = cyc;
        wait_done(60, "b2b1", d1);
        wait_done(60, "b2b2", d2);
        start = 1'b0;
        chk("b2b_first_latency", d1 - scyc, 21);
        chk("b2b_spacing", d2 - d1, 22);
        chk("b2b_nwrites", wq_a.size(), 8);
        tick(4);

        // Randomized matrices and start patterns
        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 4; a++) begin mem_a[a] = 8'($urandom); mem_b[a] = 8'($urandom); end
            clear_logs();
            tick($urandom_range(0, 3));
            start = 1'b1;
            for (int n = 0; n < 15; n++) begin
                tick(1);
                start = 1'($urandom_range(0, 1));
            end
            start = 1'b0;
            wait_done(60, "rand", d1);
            chk("rand_nwrites", wq_v.size(), 4);
            foreach (wq_v[q]) chk("rand_value", wq_v[q], dot(q / COL, q % COL));
            tick(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
